rotate_monitor: RTL

Decoder for the rotating-square seven-segment drive: samples the active-low `sseg_pattern`/`an` pair produced by the rotate block, recovers the square's position (0–7), classifies each move as clockwise, counter-clockwise or illegal jump, and counts steps. Sits beside the rotate block in simulation benches and on-board self-check builds. It is a pure observer and drives nothing back into the display path.

---
 rtl/rotate_pkg.sv | 51 +++++
 rtl/rotate_monitor_filter.sv | 37 +++
 rtl/rotate_monitor.sv | 131 +++++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared constants, types and frame decoder for the rotating-square monitor.
// Latency: none (combinational helper). Backpressure: none.
// Positions 0-3 use the upper square on digits 3..0; 4-7 the lower square on digits 0..3.
package rotate_pkg;

   localparam int POS_W = 3;

   localparam logic [7:0] SSEG_UPPER = 8'h9C;
   localparam logic [7:0] SSEG_LOWER = 8'hA3;

   localparam logic [3:0] AN_DIG3  = 4'b0111;
   localparam logic [3:0] AN_DIG2  = 4'b1011;
   localparam logic [3:0] AN_DIG1  = 4'b1101;
   localparam logic [3:0] AN_DIG0  = 4'b1110;
   localparam logic [3:0] AN_BLANK = 4'hF;

   typedef enum logic {ACQUIRE, TRACK} state_t;

   typedef enum logic [1:0] {VALID, BLANK, BAD} frame_class_t;

   typedef struct packed {
      logic [7:0] pattern;
      logic [3:0] an;
   } frame_t;

   typedef struct packed {
      frame_class_t       cls;
      logic [POS_W-1:0]   pos;
   } decode_t;

   function automatic decode_t decode_frame(input frame_t f);
      decode_t d;
      logic    upper;
      d.cls = BAD;
      d.pos = '0;
      upper = (f.pattern == SSEG_UPPER);
      if (f.an == AN_BLANK) begin
         d.cls = BLANK;
      end else if (upper || (f.pattern == SSEG_LOWER)) begin
         case (f.an)
            AN_DIG3: begin d.cls = VALID; d.pos = upper ? 3'd0 : 3'd7; end
            AN_DIG2: begin d.cls = VALID; d.pos = upper ? 3'd1 : 3'd6; end
            AN_DIG1: begin d.cls = VALID; d.pos = upper ? 3'd2 : 3'd5; end
            AN_DIG0: begin d.cls = VALID; d.pos = upper ? 3'd3 : 3'd4; end
            default: d.cls = BAD;
         endcase
      end
      return d;
   endfunction

endpackage

// File: rtl/rotate_monitor_filter.sv
// Input register plus stability counter; emits a one-shot accept per stable run.
// Latency: accept is high STABLE_CYCLES-1 cycles after the first edge sampling a new value.
// Backpressure: none; samples every cycle.
module sseg_frame_filter
   import rotate_pkg::*;
#(
   parameter int STABLE_CYCLES = 2
) (
   input  logic   clk,
   input  logic   reset,
   input  frame_t frame_in,
   output frame_t frame,
   output logic   accept
);

   localparam int CW = $clog2(STABLE_CYCLES + 2);

   logic [CW-1:0] cnt;

   // cnt saturates one past the threshold so a run is accepted exactly once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame <= '0;
         cnt   <= '0;
      end else begin
         frame <= frame_in;
         if ((frame_in != frame) || (cnt == '0)) begin
            cnt <= CW'(1);
         end else if (cnt <= CW'(STABLE_CYCLES)) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign accept = (cnt == CW'(STABLE_CYCLES));

endmodule

// File: rtl/rotate_monitor.sv
// Observer for the rotating-square display: recovers position, classifies moves, counts steps.
// Latency: outputs update STABLE_CYCLES edges after the first edge sampling a new frame.
// Backpressure: none; pure observer, drives nothing back.
module rotate_monitor
   import rotate_pkg::*;
#(
   parameter int STABLE_CYCLES = 2,
   parameter int STALL_CYCLES  = 1024,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             sseg_pattern,
   input  logic [3:0]             an,
   output logic [POS_W-1:0]       position,
   output logic                   locked,
   output logic                   step,
   output logic                   clockwise,
   output logic                   jump,
   output logic                   bad_frame,
   output logic [COUNT_WIDTH-1:0] step_count,
   output logic                   stalled
);

   localparam int SW = $clog2(STALL_CYCLES + 1);

   frame_t            in_frame;
   frame_t            stable_frame;
   logic              accept;
   decode_t           dec;
   logic [POS_W-1:0]  delta;

   state_t            state_q, state_d;
   logic [POS_W-1:0]  pos_d;
   logic              cw_d, step_d, jump_d, bad_d, stalled_d;
   logic [COUNT_WIDTH-1:0] count_d;
   logic [SW-1:0]     stall_cnt, stall_cnt_d;

   assign in_frame = {sseg_pattern, an};

   sseg_frame_filter #(
      .STABLE_CYCLES (STABLE_CYCLES)
   ) u_filter (
      .clk      (clk),
      .reset    (reset),
      .frame_in (in_frame),
      .frame    (stable_frame),
      .accept   (accept)
   );

   assign dec   = decode_frame(stable_frame);
   assign delta = dec.pos - position;

   always_comb begin
      state_d     = state_q;
      pos_d       = position;
      cw_d        = clockwise;
      step_d      = 1'b0;
      jump_d      = 1'b0;
      bad_d       = 1'b0;
      count_d     = step_count;
      stall_cnt_d = stall_cnt;
      stalled_d   = stalled;

      if (accept) begin
         if (dec.cls == BAD) begin
            bad_d = 1'b1;
         end else if (dec.cls == VALID) begin
            if (state_q == ACQUIRE) begin
               state_d = TRACK;
               pos_d   = dec.pos;
            end else if (delta == 3'd1) begin
               step_d = 1'b1;
               cw_d   = 1'b1;
               pos_d  = dec.pos;
            end else if (delta == 3'd7) begin
               step_d = 1'b1;
               cw_d   = 1'b0;
               pos_d  = dec.pos;
            end else if (delta != 3'd0) begin
               jump_d = 1'b1;
               pos_d  = dec.pos;
            end
         end
      end

      if (step_d && (step_count != '1)) begin
         count_d = step_count + COUNT_WIDTH'(1);
      end

      // a step in the threshold cycle wins over the stall indication
      if (state_q == TRACK) begin
         if (step_d) begin
            stall_cnt_d = '0;
            stalled_d   = 1'b0;
         end else if (stall_cnt != SW'(STALL_CYCLES)) begin
            stall_cnt_d = stall_cnt + SW'(1);
            if (stall_cnt_d == SW'(STALL_CYCLES)) begin
               stalled_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ACQUIRE;
         position   <= '0;
         clockwise  <= 1'b0;
         step       <= 1'b0;
         jump       <= 1'b0;
         bad_frame  <= 1'b0;
         step_count <= '0;
         stall_cnt  <= '0;
         stalled    <= 1'b0;
      end else begin
         state_q    <= state_d;
         position   <= pos_d;
         clockwise  <= cw_d;
         step       <= step_d;
         jump       <= jump_d;
         bad_frame  <= bad_d;
         step_count <= count_d;
         stall_cnt  <= stall_cnt_d;
         stalled    <= stalled_d;
      end
   end

   assign locked = (state_q == TRACK);

endmodule
